// File: rtl/pencoder_pkg.sv
// Shared display constants and helpers for the priority-encoder display slice.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package pencoder_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

  // Decimal split of a code into two BCD digits.
  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } bcd_t;

  // Any non-decimal code (including BCD_BLANK) renders as a dark digit.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] v);
    logic [SEG_W-1:0] s;
    case (v)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_mux.sv
// Time-multiplexed 7-segment driver: refresh counter, digit select, one-hot
// digit enable and registered segment pattern for the selected digit.
module seg_mux
  import pencoder_pkg::*;
#(
  parameter int unsigned N_DIG       = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_DIG-1:0][BCD_W-1:0] digits,
  input  logic [N_DIG-1:0]            blank,
  output logic [SEG_W-1:0]            Y,
  output logic [N_DIG-1:0]            Dig
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned SEL_W = $clog2(N_DIG);

  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] sel_nxt;
  logic             wrap;

  // Next digit is computed ahead so Dig and Y switch on the same edge.
  always_comb begin
    wrap    = (cnt == CNT_W'(REFRESH_DIV - 1));
    sel_nxt = sel;
    if (wrap) begin
      sel_nxt = (sel == SEL_W'(N_DIG - 1)) ? '0 : sel + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sel <= '0;
      Dig <= N_DIG'(1);
      Y   <= SEG_BLANK;
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      sel <= sel_nxt;
      Dig <= N_DIG'(1) << sel_nxt;
      Y   <= blank[sel_nxt] ? SEG_BLANK : seg_decode(digits[sel_nxt]);
    end
  end

endmodule

// File: rtl/pencoder_display.sv
// Registered priority encoder with capture-and-hold, exporting a binary code
// and showing the selected index in decimal on a multiplexed display.
module pencoder_display
  import pencoder_pkg::*;
#(
  parameter  int unsigned N_IN        = 16,
  parameter  int unsigned N_DIG       = 4,
  parameter  int unsigned REFRESH_DIV = 50000,
  localparam int unsigned CW          = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   b,
  input  logic              latch_en,
  input  logic              clr,
  output logic [CW-1:0]     code,
  output logic              valid,
  output logic [SEG_W-1:0]  Y,
  output logic [N_DIG-1:0]  Dig,
  output logic              dp
);

  logic [N_IN-1:0]            b_q;
  logic                       held;
  logic                       any;
  logic [CW-1:0]              idx;
  logic [6:0]                 code_w;
  bcd_t                       bcd;
  logic [N_DIG-1:0][BCD_W-1:0] digits;
  logic [N_DIG-1:0]           blank;

  // Highest-index asserted request wins; idx is 0 when nothing is asserted.
  always_comb begin
    any = |b_q;
    idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (b_q[i]) idx = CW'(i);
    end
  end

  // A clr in latch mode only releases the hold; capture resumes next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q   <= '0;
      code  <= '0;
      valid <= 1'b0;
      held  <= 1'b0;
    end else begin
      b_q <= b;
      if (!latch_en) begin
        held  <= 1'b0;
        code  <= idx;
        valid <= any;
      end else if (clr) begin
        held  <= 1'b0;
      end else if (!held) begin
        code  <= idx;
        valid <= any;
        held  <= any;
      end
    end
  end

  // Decimal split by threshold compares; codes never exceed 63.
  always_comb begin
    code_w    = 7'(code);
    bcd.tens  = '0;
    bcd.units = code_w[3:0];
    for (int t = 1; t <= 6; t++) begin
      if (code_w >= 7'(10 * t)) begin
        bcd.tens  = 4'(t);
        bcd.units = 4'(code_w - 7'(10 * t));
      end
    end
  end

  // Units on digit 0, tens on digit 1 with leading-zero blanking, rest dark.
  always_comb begin
    digits    = {N_DIG{BCD_BLANK}};
    digits[0] = bcd.units;
    digits[1] = bcd.tens;
    blank     = '1;
    blank[0]  = !valid;
    blank[1]  = !valid || (bcd.tens == 4'd0);
  end

  seg_mux #(
    .N_DIG       (N_DIG),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_seg_mux (
    .clk    (clk),
    .rst    (rst),
    .digits (digits),
    .blank  (blank),
    .Y      (Y),
    .Dig    (Dig)
  );

  assign dp = 1'b0;

endmodule

// File: tb/tb_pencoder_display.sv
// Scoreboard bench for pencoder_display: a driver predicts each edge's outputs
// from a behavioural model and a negedge monitor compares them.
module tb_pencoder_display;

  localparam int NIN  = 16;
  localparam int NDIG = 4;
  localparam int DIV  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NIN-1:0]  b;
  logic            latch_en;
  logic            clr;
  logic [3:0]      code;
  logic            valid;
  logic [6:0]      Y;
  logic [NDIG-1:0] Dig;
  logic            dp;

  pencoder_display #(
    .N_IN        (NIN),
    .N_DIG       (NDIG),
    .REFRESH_DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .b        (b),
    .latch_en (latch_en),
    .clr      (clr),
    .code     (code),
    .valid    (valid),
    .Y        (Y),
    .Dig      (Dig),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      code;
    logic            valid;
    logic [6:0]      y;
    logic [NDIG-1:0] dig;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   active = 1'b0;

  // Model state: request register, shown code/valid, hold flag, edges since reset.
  logic [NIN-1:0] m_bq;
  int             m_code;
  bit             m_valid;
  bit             m_held;
  int             m_k;

  function automatic int msb(input logic [NIN-1:0] v);
    logic [NIN-1:0] t;
    int n;
    t = v;
    n = 0;
    while (t > 1) begin
      t = t >> 1;
      n++;
    end
    return n;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] digit_pattern(input int sel, input int c, input bit v);
    if (!v) return 7'b0;
    if (sel == 0) return seg_of(c % 10);
    if (sel == 1) return (c / 10 == 0) ? 7'b0 : seg_of(c / 10);
    return 7'b0;
  endfunction

  task automatic step(input logic r, input logic [NIN-1:0] bb, input logic le, input logic cl);
    exp_t e;
    int   old_code;
    bit   old_valid;
    bit   has_req;
    int   sel;
    rst      = r;
    b        = bb;
    latch_en = le;
    clr      = cl;
    if (r) begin
      m_bq = '0; m_code = 0; m_valid = 0; m_held = 0; m_k = 0;
      e.dig = NDIG'(1);
      e.y   = 7'b0;
    end else begin
      old_code  = m_code;
      old_valid = m_valid;
      has_req   = (m_bq != 0);
      if (!le) begin
        m_held  = 0;
        m_code  = has_req ? msb(m_bq) : 0;
        m_valid = has_req;
      end else if (cl) begin
        m_held = 0;
      end else if (!m_held) begin
        m_code  = has_req ? msb(m_bq) : 0;
        m_valid = has_req;
        m_held  = has_req;
      end
      m_bq  = bb;
      m_k++;
      sel   = (m_k / DIV) % NDIG;
      e.dig = NDIG'(1) << sel;
      e.y   = digit_pattern(sel, old_code, old_valid);
    end
    e.code  = 4'(m_code);
    e.valid = m_valid;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (active) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: no expected entry at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("code",  16'(code),  16'(e.code));
          chk("valid", 16'(valid), 16'(e.valid));
          chk("Y",     16'(Y),     16'(e.y));
          chk("Dig",   16'(Dig),   16'(e.dig));
          chk("dp",    16'(dp),    16'h0);
        end
      end
    end
  end

  initial begin
    logic [NIN-1:0] rb;
    bit             le;
    int             pick;
    rst = 1'b1; b = '0; latch_en = 1'b0; clr = 1'b0;
    active = 1'b1;
    step(1, '0, 0, 0);
    step(1, '0, 0, 0);

    // Idle display walks all digits while blank.
    repeat (20) step(0, 16'h0000, 0, 0);
    // Live tracking: single digit, two digits, then release.
    repeat (20) step(0, 16'h0025, 0, 0);
    repeat (20) step(0, 16'h8001, 0, 0);
    repeat (20) step(0, 16'h0000, 0, 0);
    // Capture-and-hold, then clr with the new request present.
    repeat (3)  step(0, 16'h0008, 1, 0);
    repeat (16) step(0, 16'h4000, 1, 0);
    step(0, 16'h4000, 1, 1);
    repeat (16) step(0, 16'h4000, 1, 0);
    // clr coincident with a new request, then drop latch_en while held.
    step(0, 16'h0200, 1, 1);
    repeat (6) step(0, 16'h0200, 1, 0);
    repeat (6) step(0, 16'h0040, 0, 0);
    // Reset mid-frame while holding on the third digit slot.
    repeat (3) step(0, 16'h0100, 1, 0);
    for (int i = 0; i < 40 && !(((m_k / DIV) % NDIG) == 2 && m_held); i++)
      step(0, 16'h0800, 1, 0);
    step(1, 16'h0800, 1, 0);
    repeat (8) step(0, 16'h0800, 1, 0);

    // Randomised traffic with mode changes, clr pulses and rare resets.
    le = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      pick = $urandom_range(0, 3);
      if (pick == 0)      rb = '0;
      else if (pick == 1) rb = NIN'(1) << $urandom_range(0, NIN - 1);
      else                rb = NIN'($urandom);
      if ($urandom_range(0, 24) == 0) le = ~le;
      step(($urandom_range(0, 299) == 0), rb, le, ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    #1;
    active = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
